control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 61 ++++++
 rtl/control_unit_decode.sv | 93 +++++++++
 rtl/control_unit.sv | 84 ++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared state numbers, ALU opcodes, sequencing modes and the control-word layout
// for the microsequencer control unit.
package control_unit_pkg;

    localparam logic [6:0] ST_IDLE     = 7'd0;
    localparam logic [6:0] ST_FETCH1   = 7'd1;
    localparam logic [6:0] ST_FETCH2   = 7'd2;
    localparam logic [6:0] ST_FETCH3   = 7'd3;
    localparam logic [6:0] ST_DECODE   = 7'd4;
    localparam logic [6:0] ST_DP_REG   = 7'd10;
    localparam logic [6:0] ST_DP_IMM   = 7'd11;
    localparam logic [6:0] ST_LD_ADDR  = 7'd20;
    localparam logic [6:0] ST_LD_READ  = 7'd21;
    localparam logic [6:0] ST_LD_WB    = 7'd22;
    localparam logic [6:0] ST_ST_MDR   = 7'd48;
    localparam logic [6:0] ST_ST_WRITE = 7'd49;

    localparam logic [4:0] ALU_NONE   = 5'b00000;
    localparam logic [4:0] ALU_ADD    = 5'b00100;
    localparam logic [4:0] ALU_PASS_B = 5'b01101;

    localparam logic [1:0] T_JUMP     = 2'b00;
    localparam logic [1:0] T_DISPATCH = 2'b01;

    localparam logic [3:0] PX_ALL     = 4'b1111;

    typedef struct packed {
        logic       rfld;
        logic       irld;
        logic       marld;
        logic       mdrld;
        logic       frld;
        logic       rw;
        logic       mov;
        logic       type_data;
        logic [3:0] px;
        logic [1:0] ma;
        logic [1:0] mb;
        logic [1:0] mc;
        logic [1:0] mi;
        logic       md;
        logic       me;
        logic       mf;
        logic       mg;
        logic       mh;
        logic [4:0] op;
        logic       e;
        logic [1:0] t;
        logic [5:0] s;
    } ctrl_word_t;

    function automatic logic is_legal_state(input logic [6:0] st);
        case (st)
            ST_IDLE, ST_FETCH1, ST_FETCH2, ST_FETCH3, ST_DECODE,
            ST_DP_REG, ST_DP_IMM, ST_LD_ADDR, ST_LD_READ, ST_LD_WB,
            ST_ST_MDR, ST_ST_WRITE: is_legal_state = 1'b1;
            default:                is_legal_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational state-number to control-word decode; unlisted states give all zeros.
// Zero latency, no backpressure.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  logic [6:0] state,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            ST_IDLE: begin
                cw.t = T_JUMP;
                cw.s = ST_FETCH1[5:0];
            end
            ST_FETCH1: begin
                cw.marld = 1'b1;
                cw.rfld  = 1'b1;
                cw.ma    = 2'b10;
                cw.mb    = 2'b11;
                cw.mc    = 2'b01;
                cw.op    = ALU_ADD;
                cw.s     = ST_FETCH2[5:0];
            end
            ST_FETCH2: begin
                cw.mdrld = 1'b1;
                cw.mov   = 1'b1;
                cw.rw    = 1'b1;
                cw.mf    = 1'b1;
                cw.px    = PX_ALL;
                cw.s     = ST_FETCH3[5:0];
            end
            ST_FETCH3: begin
                cw.irld = 1'b1;
                cw.mov  = 1'b1;
                cw.rw   = 1'b1;
                cw.mf   = 1'b1;
                cw.px   = PX_ALL;
                cw.s    = ST_DECODE[5:0];
            end
            ST_DECODE: begin
                cw.e = 1'b1;
                cw.t = T_DISPATCH;
                cw.s = ST_IDLE[5:0];
            end
            ST_DP_REG, ST_DP_IMM: begin
                // Register and immediate forms differ only in the B-operand source.
                cw.rfld = 1'b1;
                cw.frld = 1'b1;
                cw.md   = 1'b1;
                cw.mb   = (state == ST_DP_IMM) ? 2'b01 : 2'b00;
                cw.s    = ST_FETCH1[5:0];
            end
            ST_LD_ADDR: begin
                cw.marld = 1'b1;
                cw.mb    = 2'b01;
                cw.op    = ALU_ADD;
                cw.s     = ST_LD_READ[5:0];
            end
            ST_LD_READ: begin
                cw.mdrld = 1'b1;
                cw.mov   = 1'b1;
                cw.rw    = 1'b1;
                cw.mf    = 1'b1;
                cw.px    = PX_ALL;
                cw.s     = ST_LD_WB[5:0];
            end
            ST_LD_WB: begin
                cw.rfld = 1'b1;
                cw.mb   = 2'b10;
                cw.op   = ALU_PASS_B;
                cw.s    = ST_FETCH1[5:0];
            end
            ST_ST_MDR: begin
                cw.mdrld = 1'b1;
                cw.mh    = 1'b1;
                cw.mb    = 2'b00;
                cw.op    = ALU_PASS_B;
                cw.s     = ST_ST_WRITE[5:0];
            end
            ST_ST_WRITE: begin
                // Word-sized memory write: rw and type_data stay 0.
                cw.mov = 1'b1;
                cw.px  = PX_ALL;
                cw.mi  = 2'b01;
                cw.s   = ST_FETCH1[5:0];
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Registered microsequencer control unit; optional illegal_state flag under CONTROL_UNIT_ILLEGAL_STATE_EN.
// One-cycle latency from sampled state to outputs, no backpressure.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] state,
    output logic       RFLd,
    output logic       IRLd,
    output logic       MARLd,
    output logic       MDRLd,
    output logic       FRLd,
    output logic       RW,
    output logic       MOV,
    output logic       typeData,
    output logic [3:0] px,
    output logic [1:0] MA,
    output logic [1:0] MB,
    output logic [1:0] MC,
    output logic [1:0] MI,
    output logic       MD,
    output logic       ME,
    output logic       MF,
    output logic       MG,
    output logic       MH,
    output logic [4:0] OP,
    output logic       E,
    output logic [1:0] T,
    output logic [5:0] S
`ifdef CONTROL_UNIT_ILLEGAL_STATE_EN
    ,
    output logic       illegal_state
`endif
);

    ctrl_word_t cw_d;
    ctrl_word_t cw_q;

    control_unit_decode u_decode (
        .state (state),
        .cw    (cw_d)
    );

    always_ff @(posedge clk) begin
        if (reset) cw_q <= '0;
        else       cw_q <= cw_d;
    end

`ifdef CONTROL_UNIT_ILLEGAL_STATE_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= ~is_legal_state(state);
    end

    assign illegal_state = illegal_q;
`endif

    assign RFLd     = cw_q.rfld;
    assign IRLd     = cw_q.irld;
    assign MARLd    = cw_q.marld;
    assign MDRLd    = cw_q.mdrld;
    assign FRLd     = cw_q.frld;
    assign RW       = cw_q.rw;
    assign MOV      = cw_q.mov;
    assign typeData = cw_q.type_data;
    assign px       = cw_q.px;
    assign MA       = cw_q.ma;
    assign MB       = cw_q.mb;
    assign MC       = cw_q.mc;
    assign MI       = cw_q.mi;
    assign MD       = cw_q.md;
    assign ME       = cw_q.me;
    assign MF       = cw_q.mf;
    assign MG       = cw_q.mg;
    assign MH       = cw_q.mh;
    assign OP       = cw_q.op;
    assign E        = cw_q.e;
    assign T        = cw_q.t;
    assign S        = cw_q.s;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit with hand-written expected control words.
module tb_control_unit;
    import control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] state;
    logic       RFLd, IRLd, MARLd, MDRLd, FRLd, RW, MOV, typeData;
    logic [3:0] px;
    logic [1:0] MA, MB, MC, MI;
    logic       MD, ME, MF, MG, MH;
    logic [4:0] OP;
    logic       E;
    logic [1:0] T;
    logic [5:0] S;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    ctrl_word_t obs;
    ctrl_word_t exp_cw;

    always #5 clk = ~clk;

    control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .state    (state),
        .RFLd     (RFLd),
        .IRLd     (IRLd),
        .MARLd    (MARLd),
        .MDRLd    (MDRLd),
        .FRLd     (FRLd),
        .RW       (RW),
        .MOV      (MOV),
        .typeData (typeData),
        .px       (px),
        .MA       (MA),
        .MB       (MB),
        .MC       (MC),
        .MI       (MI),
        .MD       (MD),
        .ME       (ME),
        .MF       (MF),
        .MG       (MG),
        .MH       (MH),
        .OP       (OP),
        .E        (E),
        .T        (T),
        .S        (S)
`ifdef CONTROL_UNIT_ILLEGAL_STATE_EN
        ,
        .illegal_state (illegal)
`endif
    );

`ifndef CONTROL_UNIT_ILLEGAL_STATE_EN
    assign illegal = 1'b0;
`endif

    assign obs = '{rfld: RFLd, irld: IRLd, marld: MARLd, mdrld: MDRLd, frld: FRLd,
                   rw: RW, mov: MOV, type_data: typeData, px: px,
                   ma: MA, mb: MB, mc: MC, mi: MI,
                   md: MD, me: ME, mf: MF, mg: MG, mh: MH,
                   op: OP, e: E, t: T, s: S};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step(input logic rst, input logic [6:0] st);
        reset = rst;
        state = st;
        @(posedge clk);
        #1;
    endtask

    task automatic check_illegal(input string tag, input logic want);
`ifdef CONTROL_UNIT_ILLEGAL_STATE_EN
        check(tag, {63'd0, illegal}, {63'd0, want});
`else
        check(tag, {63'd0, illegal}, 64'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        state = 7'd1;

        // Reset held for two edges with a legal state present.
        step(1'b1, 7'd1);
        step(1'b1, 7'd1);
        check("reset_all_zero", 64'(obs), 64'd0);
        check_illegal("reset_illegal", 1'b0);

        step(1'b0, 7'd1);
        exp_cw = '0; exp_cw.marld = 1; exp_cw.rfld = 1; exp_cw.ma = 2'b10;
        exp_cw.mb = 2'b11; exp_cw.mc = 2'b01; exp_cw.op = 5'b00100; exp_cw.s = 6'd2;
        check("fetch1", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd0);
        exp_cw = '0; exp_cw.s = 6'd1;
        check("idle", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd49);
        exp_cw = '0; exp_cw.mov = 1; exp_cw.px = 4'b1111; exp_cw.mi = 2'b01; exp_cw.s = 6'd1;
        check("st_write", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd2);
        exp_cw = '0; exp_cw.mdrld = 1; exp_cw.mov = 1; exp_cw.rw = 1; exp_cw.mf = 1;
        exp_cw.px = 4'b1111; exp_cw.s = 6'd3;
        check("fetch2", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd3);
        exp_cw = '0; exp_cw.irld = 1; exp_cw.mov = 1; exp_cw.rw = 1; exp_cw.mf = 1;
        exp_cw.px = 4'b1111; exp_cw.s = 6'd4;
        check("fetch3", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd4);
        exp_cw = '0; exp_cw.e = 1; exp_cw.t = 2'b01; exp_cw.s = 6'd0;
        check("decode", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd10);
        exp_cw = '0; exp_cw.rfld = 1; exp_cw.frld = 1; exp_cw.md = 1; exp_cw.s = 6'd1;
        check("dp_reg", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd11);
        exp_cw.mb = 2'b01;
        check("dp_imm", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd77);
        check("illegal77_zero", 64'(obs), 64'd0);
        check_illegal("illegal77_flag", 1'b1);

        step(1'b0, 7'd22);
        exp_cw = '0; exp_cw.rfld = 1; exp_cw.mb = 2'b10; exp_cw.op = 5'b01101; exp_cw.s = 6'd1;
        check("ld_wb", 64'(obs), 64'(exp_cw));
        check_illegal("ld_wb_flag", 1'b0);

        step(1'b0, 7'd20);
        exp_cw = '0; exp_cw.marld = 1; exp_cw.mb = 2'b01; exp_cw.op = 5'b00100; exp_cw.s = 6'd21;
        check("ld_addr", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd48);
        exp_cw = '0; exp_cw.mdrld = 1; exp_cw.mh = 1; exp_cw.op = 5'b01101; exp_cw.s = 6'd49;
        check("st_mdr", 64'(obs), 64'(exp_cw));

        step(1'b0, 7'd21);
        exp_cw = '0; exp_cw.mdrld = 1; exp_cw.mov = 1; exp_cw.rw = 1; exp_cw.mf = 1;
        exp_cw.px = 4'b1111; exp_cw.s = 6'd22;
        check("ld_read", 64'(obs), 64'(exp_cw));

        // Reset must override a live load-read state.
        step(1'b1, 7'd21);
        check("reset_over_ld_read", 64'(obs), 64'd0);

        step(1'b0, 7'd3);
        exp_cw = '0; exp_cw.irld = 1; exp_cw.mov = 1; exp_cw.rw = 1; exp_cw.mf = 1;
        exp_cw.px = 4'b1111; exp_cw.s = 6'd4;
        check("release_fetch3", 64'(obs), 64'(exp_cw));

        // Boundaries of the undefined-state ranges.
        step(1'b0, 7'd5);
        check("state5_zero", 64'(obs), 64'd0);
        check_illegal("state5_flag", 1'b1);
        step(1'b0, 7'd12);
        check("state12_zero", 64'(obs), 64'd0);
        step(1'b0, 7'd50);
        check("state50_zero", 64'(obs), 64'd0);
        step(1'b0, 7'd127);
        check("state127_zero", 64'(obs), 64'd0);
        check_illegal("state127_flag", 1'b1);
        step(1'b0, 7'd0);
        check_illegal("idle_flag", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
